reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader.sv | 127 ++++++++++++
 tb/tb_reg_dump_reader.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// ---------------------------------------------------------------------------
// reg_dump_reader
//
// Walks a register file from address 0 up to NUM_REGS-1. Each entry is
// captured into an output holding register and presented to a downstream
// consumer with a valid/ready handshake. One word is delivered every two
// cycles when the consumer is always ready. A single-cycle done pulse
// follows the last accepted word.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   reset      : synchronous, active-low reset
//   start      : request one full dump (only looked at while idle)
//   abort      : terminate the dump in progress (no done pulse)
//   rf_addr    : read address to the register file (equals the walk index)
//   rf_data    : combinational read data for rf_addr
//   out_valid  : out_addr/out_data hold a captured word
//   out_ready  : consumer accepts the word when out_valid is also high
//   out_addr   : register index of the presented word
//   out_data   : snapshot of the register contents for out_addr
//   busy       : high whenever a dump is in progress (any state but IDLE)
//   done       : one-cycle pulse after the last word was accepted
// ---------------------------------------------------------------------------
module reg_dump_reader #(
    parameter int NUM_REGS = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [4:0] LAST_INDEX = 5'(NUM_REGS - 1);

    state_t      state;
    state_t      state_next;
    logic [4:0]  index;
    logic [4:0]  index_next;
    logic        capture;

    // State, walk index and output holding registers. The holding
    // registers only load on the READ cycle, so later writes into the
    // register file cannot disturb a word that is already presented.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            index    <= 5'd0;
            out_addr <= 5'd0;
            out_data <= 32'd0;
        end else begin
            state <= state_next;
            index <= index_next;
            if (capture) begin
                out_addr <= index;
                out_data <= rf_data;
            end
        end
    end

    // Next-state logic. Abort beats everything, including a handshake
    // landing in the same cycle, and also beats start while idle. Every
    // path back to IDLE clears the index so rf_addr reads 0 there.
    always_comb begin
        state_next = state;
        index_next = index;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                index_next = 5'd0;
                if (start && !abort) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (abort) begin
                    state_next = IDLE;
                    index_next = 5'd0;
                end else begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_next = IDLE;
                    index_next = 5'd0;
                end else if (out_ready) begin
                    if (index == LAST_INDEX) begin
                        state_next = DONE;
                    end else begin
                        index_next = index + 5'd1;
                        state_next = READ;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                index_next = 5'd0;
            end
            default: begin
                state_next = IDLE;
                index_next = 5'd0;
            end
        endcase
    end

    assign rf_addr   = index;
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_reader
//
// Self-checking bench for reg_dump_reader. Two instances share the clock,
// reset and a behavioural register file: one with 9 entries and one with a
// single entry. Expected words come from a snapshot of the register file
// taken before each dump and from the cycle timing of the dump itself.
// ---------------------------------------------------------------------------
module tb_reg_dump_reader;

    localparam int N = 9;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    logic        start1;
    logic        abort1;
    logic [4:0]  rf_addr1;
    logic [31:0] rf_data1;
    logic        out_valid1;
    logic        out_ready1;
    logic [4:0]  out_addr1;
    logic [31:0] out_data1;
    logic        busy1;
    logic        done1;

    logic [31:0] rf [0:31];

    int errors;
    int checks;

    assign rf_data  = rf[rf_addr];
    assign rf_data1 = rf[rf_addr1];

    reg_dump_reader #(.NUM_REGS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    reg_dump_reader #(.NUM_REGS(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .abort     (abort1),
        .rf_addr   (rf_addr1),
        .rf_data   (rf_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_addr  (out_addr1),
        .out_data  (out_data1),
        .busy      (busy1),
        .done      (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge, where outputs are
    // observed and inputs for the next edge are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, out_valid, done} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got busy/valid/done=%b want 000", {busy, out_valid, done});
        end
        checks++;
        if (rf_addr !== 5'd0 || out_addr !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_addr: got rf_addr=%0d out_addr=%0d want 0/0", rf_addr, out_addr);
        end
        checks++;
        if (out_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h want 0", out_data);
        end
        checks++;
        if ({busy1, out_valid1, done1} !== 3'b000 || rf_addr1 !== 5'd0 || out_data1 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_dut1: got flags=%b rf_addr=%0d data=%h want 0", {busy1, out_valid1, done1}, rf_addr1, out_data1);
        end
        reset = 1'b1;
        tick();
    endtask

    // Full dump with the consumer always ready: the expected state of each
    // cycle follows from the two-cycles-per-word timing.
    task automatic test_full_dump();
        int k;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            if (c <= 2 * N) begin
                k = (c - 1) / 2;
                if (c % 2 == 1) begin
                    checks++;
                    if ({busy, out_valid, done} !== 3'b100 || rf_addr !== 5'(k)) begin
                        errors++;
                        $display("[TB] FAIL full_read c=%0d: got flags=%b rf_addr=%0d want 100/%0d", c, {busy, out_valid, done}, rf_addr, k);
                    end
                end else begin
                    checks++;
                    if ({busy, out_valid, done} !== 3'b110 || out_addr !== 5'(k) || out_data !== 32'h100 + k) begin
                        errors++;
                        $display("[TB] FAIL full_hold c=%0d: got flags=%b addr=%0d data=%h want 110/%0d/%h", c, {busy, out_valid, done}, out_addr, out_data, k, 32'h100 + k);
                    end
                end
            end else if (c == 2 * N + 1) begin
                checks++;
                if ({busy, out_valid, done} !== 3'b101) begin
                    errors++;
                    $display("[TB] FAIL full_done c=%0d: got flags=%b want 101", c, {busy, out_valid, done});
                end
            end else begin
                checks++;
                if ({busy, out_valid, done} !== 3'b000 || rf_addr !== 5'd0) begin
                    errors++;
                    $display("[TB] FAIL full_idle c=%0d: got flags=%b rf_addr=%0d want 000/0", c, {busy, out_valid, done}, rf_addr);
                end
            end
            tick();
        end
    endtask

    // Random register contents and random consumer stalls, with a forced
    // five-cycle stall at word 3 during which r3 is overwritten.
    task automatic test_backpressure();
        logic [31:0] snap [0:31];
        int  k;
        int  hold_left;
        bit  hold_started;
        bit  seen_done;
        for (int i = 0; i < 32; i++) begin
            rf[i]   = $urandom;
            snap[i] = rf[i];
        end
        k = 0;
        hold_left = 0;
        hold_started = 1'b0;
        seen_done = 1'b0;
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            if (done) begin
                seen_done = 1'b1;
                checks++;
                if (k != N) begin
                    errors++;
                    $display("[TB] FAIL bp_count: got %0d words want %0d", k, N);
                end
            end
            if (out_valid) begin
                checks++;
                if (k >= N || out_addr !== 5'(k) || out_data !== snap[k]) begin
                    errors++;
                    $display("[TB] FAIL bp_word k=%0d: got addr=%0d data=%h", k, out_addr, out_data);
                end
                if (k == 3 && !hold_started) begin
                    hold_started = 1'b1;
                    hold_left = 5;
                    rf[3] = 32'hDEAD;
                end
                if (hold_left > 0) begin
                    out_ready = 1'b0;
                    hold_left--;
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
                if (out_ready) k++;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            tick();
        end
        checks++;
        if (!seen_done || !hold_started) begin
            errors++;
            $display("[TB] FAIL bp_timeout: got done=%0d stall=%0d want 1/1", seen_done, hold_started);
        end
        rf[3] = snap[3];
        out_ready = 1'b1;
        tick();
    endtask

    // A second start in the middle of a dump must be dropped, not queued.
    task automatic test_restart_ignored();
        int  words;
        int  dones;
        bit  pulsed;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        words = 0;
        dones = 0;
        pulsed = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        for (int cyc = 0; cyc < 60; cyc++) begin
            start = 1'b0;
            if (done) dones++;
            if (out_valid) begin
                checks++;
                if (out_addr !== 5'(words)) begin
                    errors++;
                    $display("[TB] FAIL restart_order: got addr=%0d want %0d", out_addr, words);
                end
                if (out_addr == 5'd4 && !pulsed) begin
                    start = 1'b1;
                    pulsed = 1'b1;
                end
                words++;
            end
            tick();
        end
        checks++;
        if (words != N || dones != 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_count: got words=%0d dones=%0d busy=%b want %0d/1/0", words, dones, busy, N);
        end
    endtask

    // Abort in HOLD at word 5 while the consumer is ready, then a clean dump.
    task automatic test_abort();
        logic [31:0] snap [0:31];
        int  words;
        int  dones;
        bit  aborted;
        for (int i = 0; i < 32; i++) begin
            rf[i]   = $urandom;
            snap[i] = rf[i];
        end
        words = 0;
        dones = 0;
        aborted = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 40 && !aborted; cyc++) begin
            if (done) dones++;
            if (out_valid) begin
                if (out_addr == 5'd5) begin
                    abort = 1'b1;
                    aborted = 1'b1;
                end else begin
                    words++;
                end
            end
            tick();
        end
        abort = 1'b0;
        checks++;
        if (!aborted) begin
            errors++;
            $display("[TB] FAIL abort_timeout: got no word 5 want word 5");
        end
        checks++;
        if ({busy, out_valid, done} !== 3'b000 || rf_addr !== 5'd0) begin
            errors++;
            $display("[TB] FAIL abort_idle: got flags=%b rf_addr=%0d want 000/0", {busy, out_valid, done}, rf_addr);
        end
        checks++;
        if (words != 5) begin
            errors++;
            $display("[TB] FAIL abort_words: got %0d want 5", words);
        end
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (done || busy) dones++;
            tick();
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got %0d done/busy cycles want 0", dones);
        end
        words = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done) dones++;
            if (out_valid) begin
                checks++;
                if (words >= N || out_addr !== 5'(words) || out_data !== snap[words]) begin
                    errors++;
                    $display("[TB] FAIL abort_redump w=%0d: got addr=%0d data=%h", words, out_addr, out_data);
                end
                words++;
            end
            tick();
        end
        checks++;
        if (words != N || dones != 1) begin
            errors++;
            $display("[TB] FAIL abort_redump_count: got words=%0d dones=%0d want %0d/1", words, dones, N);
        end
    endtask

    // Reset in HOLD at word 2, then start+abort together while idle.
    task automatic test_reset_in_hold();
        bit found;
        found = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            if (out_valid && out_addr == 5'd2) begin
                reset = 1'b0;
                found = 1'b1;
            end
            tick();
        end
        reset = 1'b1;
        checks++;
        if (!found || {busy, out_valid, done} !== 3'b000 || rf_addr !== 5'd0 ||
            out_addr !== 5'd0 || out_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL hold_reset: got found=%0d flags=%b rf_addr=%0d addr=%0d data=%h want 1/000/0/0/0",
                     found, {busy, out_valid, done}, rf_addr, out_addr, out_data);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_abort_idle: got busy=%b want 0", busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 5'd0 || out_data !== rf[0]) begin
            errors++;
            $display("[TB] FAIL reset_restart: got valid=%b addr=%0d data=%h want 1/0/%h", out_valid, out_addr, out_data, rf[0]);
        end
        for (int cyc = 0; cyc < 40 && busy; cyc++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_drain: got busy=%b want 0", busy);
        end
    endtask

    // Single-entry instance: READ, HOLD, DONE, then idle.
    task automatic test_single_reg();
        rf[0] = $urandom;
        out_ready1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if ({busy1, out_valid1, done1} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL single_read: got flags=%b want 100", {busy1, out_valid1, done1});
        end
        tick();
        checks++;
        if ({busy1, out_valid1, done1} !== 3'b110 || out_addr1 !== 5'd0 || out_data1 !== rf[0]) begin
            errors++;
            $display("[TB] FAIL single_hold: got flags=%b addr=%0d data=%h want 110/0/%h", {busy1, out_valid1, done1}, out_addr1, out_data1, rf[0]);
        end
        tick();
        checks++;
        if ({busy1, out_valid1, done1} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL single_done: got flags=%b want 101", {busy1, out_valid1, done1});
        end
        tick();
        checks++;
        if ({busy1, out_valid1, done1} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL single_idle: got flags=%b want 000", {busy1, out_valid1, done1});
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b0;
        start1     = 1'b0;
        abort1     = 1'b0;
        out_ready1 = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        #1;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_restart_ignored();
        test_abort();
        test_reset_in_hold();
        test_single_reg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
